prog_counter: RTL
=================

PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter PRE_W, default 4, meaning prescaler width in bits (legal range 1..16).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-005 The block SHALL have port init  input  1  synchronous clear of count, prescaler and status.
REQ-006 The block SHALL have port load  input  1  synchronous load of load_val.
REQ-007 The block SHALL have port load_val  input  WIDTH  value loaded when load is high.
REQ-008 The block SHALL have port cntEn  input  1  count enable; gates prescaler advance.
REQ-009 The block SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 The block SHALL have port mod_max  input  WIDTH  terminal (maximum) count value.
REQ-011 The block SHALL have port mode  input  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (behaves as wrap).
REQ-012 The block SHALL have port pre_div  input  PRE_W  prescale divisor; count steps once every pre_div+1 enabled cycles.
REQ-013 The block SHALL have port cnt  output  WIDTH  registered count value.
REQ-014 The block SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 The block SHALL have port done  output  1  sticky one-shot completion flag.

Function
REQ-016 Priority per cycle SHALL be init > load > tick; lower-priority events in the same cycle are discarded.
REQ-017 init high SHALL set cnt = 0, prescaler = 0, done = 0, tc = 0 on the next edge.
REQ-018 load high SHALL set cnt = load_val, prescaler = 0, done = 0, tc = 0 on the next edge; load_val > mod_max is accepted as-is.
REQ-019 Prescaler SHALL advance only when cntEn = 1 and done = 0; when it equals pre_div a tick is generated and it returns to 0 on the same edge.
REQ-020 cntEn = 0 SHALL hold the prescaler and cnt unchanged; pre_div = 0 SHALL tick every enabled cycle.
REQ-021 On a tick with up = 1 and cnt < mod_max, cnt SHALL become cnt+1.
REQ-022 On a tick with up = 0 and cnt > 0, cnt SHALL become cnt-1, independent of mod_max.
REQ-023 Terminal condition SHALL be cnt >= mod_max when up = 1, cnt == 0 when up = 0.
REQ-024 On a tick at terminal: wrap SHALL load 0 (up) or mod_max (down); saturate SHALL hold cnt; one-shot SHALL hold cnt and set done = 1.
REQ-025 tc SHALL be high for exactly the one cycle following every tick taken at terminal, in all modes; repeated saturate ticks at terminal pulse tc each time.
REQ-026 done = 1 SHALL freeze cnt and prescaler until init or load.
REQ-027 Changes to mod_max, up, mode or pre_div SHALL take effect on the next evaluated edge; no internal capture.
REQ-028 If pre_div is reduced below the current prescaler value, the prescaler SHALL continue to wrap at all-ones, then tick at the new pre_div.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH with no carry-out port; mod_max = 0 with up = 1 SHALL make every tick terminal.

Reset
REQ-030 rst low SHALL asynchronously force cnt = 0, prescaler = 0, tc = 0, done = 0, regardless of clk.
REQ-031 Release of rst SHALL resume normal operation on the first rising clk edge after deassertion; reset mid-count discards all progress.

Structure
REQ-032 Mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) SHALL live in shared package prog_counter_pkg.
REQ-033 The prescaler SHALL be a separate sub-module tick_gen (clk, rst, clr, en, div, tick), instantiated once.
REQ-034 cnt, tc and done SHALL be driven directly from flops.

Verification
REQ-035 WIDTH=8, pre_div=0, mode=wrap, up=1, mod_max=9, cntEn=1 for 12 cycles -> cnt 0..9,0,1; tc high one cycle after cnt=9.
REQ-036 pre_div=3, cntEn=1 -> cnt increments every 4th cycle; cntEn low 2 cycles mid-period -> period stretches by 2.
REQ-037 mode=one-shot, up=0, load_val=3 -> cnt 3,2,1,0; done=1, tc one pulse, cnt stays 0 with cntEn high; load clears done.
REQ-038 mode=saturate, up=1, mod_max=5, load_val=200 -> cnt holds 200, tc pulses on every tick.
REQ-039 init, load and tick in same cycle -> cnt = 0; load and tick only -> cnt = load_val, prescaler 0.
REQ-040 rst asserted between clock edges mid-count -> outputs 0 immediately; counting restarts from 0 after release.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared mode encodings for the programmable counter.
package prog_counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a tick every div+1 enabled cycles.
module tick_gen #(
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [PRE_W-1:0] div,
   output logic             tick
);

   localparam logic [PRE_W-1:0] ONE = PRE_W'(1);

   logic [PRE_W-1:0] pre_q, pre_d;

   assign tick = en && (pre_q == div);

   // A shrunken div lets pre_q run past it and wrap at all-ones.
   always_comb begin
      pre_d = pre_q;
      if (clr) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = tick ? '0 : pre_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pre_q <= '0;
      else      pre_q <= pre_d;
   end

endmodule

// File: rtl/prog_counter.sv
// Up/down counter with prescaler, wrap/saturate/one-shot modes.
module prog_counter
   import prog_counter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             cntEn,
   input  logic             up,
   input  logic [WIDTH-1:0] mod_max,
   input  logic [1:0]       mode,
   input  logic [PRE_W-1:0] pre_div,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;
   logic             tick;
   logic             term;
   mode_e            mode_s;

   assign mode_s = mode_e'(mode);

   tick_gen #(.PRE_W(PRE_W)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (init | load),
      .en   (cntEn & ~done_q),
      .div  (pre_div),
      .tick (tick)
   );

   assign term = up ? (cnt_q >= mod_max) : (cnt_q == '0);

   always_comb begin
      cnt_d  = cnt_q;
      tc_d   = 1'b0;
      done_d = done_q;
      if (init) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (load) begin
         cnt_d  = load_val;
         done_d = 1'b0;
      end else if (tick) begin
         if (term) begin
            tc_d = 1'b1;
            unique case (mode_s)
               MODE_WRAP,
               MODE_RSVD:    cnt_d  = up ? '0 : mod_max;
               MODE_SAT:     cnt_d  = cnt_q;
               MODE_ONESHOT: done_d = 1'b1;
               default:      cnt_d  = cnt_q;
            endcase
         end else begin
            cnt_d = up ? cnt_q + ONE : cnt_q - ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         tc_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tc_q   <= tc_d;
         done_q <= done_d;
      end
   end

   assign cnt  = cnt_q;
   assign tc   = tc_q;
   assign done = done_q;

endmodule
